ex_alu_seq: RTL

- Parametrised successor to the EX-stage ALU control decode. Merges opcode/function decode with a datapath of width WIDTH.
- Single-cycle logic, add/sub and shift/rotate operations, plus multi-cycle shift-add multiply and restoring divide.
- Sits between the ID/EX register and the EX/MEM register, with valid/ready handshakes on both sides, so multi-cycle operations stall the pipeline cleanly.

---
 rtl/ex_alu_seq_if.sv | 15 +
 rtl/ex_alu_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ex_alu_seq_if.sv
// ex_alu_seq_if: issue and result handshake bundle between the ID/EX and EX/MEM stages.
interface ex_alu_seq_if #(parameter int WIDTH = 16);
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [3:0]       opcode, funct;
    logic [WIDTH-1:0] a, b, result, result_hi;
    logic             flag_zero, flag_carry, flag_ovf, flag_dz, busy;
    modport master (
        output in_valid, opcode, funct, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, flag_zero, flag_carry, flag_ovf, flag_dz, busy
    );
    modport slave (
        input  in_valid, opcode, funct, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, flag_zero, flag_carry, flag_ovf, flag_dz, busy
    );
endinterface

// File: rtl/ex_alu_seq.sv
// ex_alu_seq: EX-stage ALU with decode, single-cycle ops and iterative multiply/divide.
module ex_alu_seq #(parameter int WIDTH = 16) (
    input logic clk,
    input logic rst,
    ex_alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
    state_t           state;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] opd, hi, lo, sc_res, m_hi, m_lo, d_hi, d_lo;
    logic [WIDTH:0]   sum, dif, madd, rs, dsub;
    logic [3:0]       op;
    logic [SHW-1:0]   sh;
    logic             sc_c, sc_v, d_ok;
    assign bus.in_ready = state == IDLE;
    assign bus.busy = state == MULT || state == DIV;
    // B-type instructions collapse onto the A-type ADD function code
    assign op = bus.opcode == 4'b0000 ? bus.funct :
                (bus.opcode == 4'b1000 || bus.opcode == 4'b1011) ? 4'd15 : 4'd0;
    assign sh = bus.b[SHW-1:0];
    assign sum = {1'b0, bus.a} + {1'b0, bus.b};
    assign dif = {1'b0, bus.a} - {1'b0, bus.b};
    always_comb begin
        sc_res = '0;
        sc_c = 1'b0;
        sc_v = 1'b0;
        case (op)
            4'd8:  sc_res = (bus.a << sh) | (bus.a >> (WIDTH - int'(sh)));
            4'd9:  sc_res = (bus.a >> sh) | (bus.a << (WIDTH - int'(sh)));
            4'd10: sc_res = bus.a << sh;
            4'd11: sc_res = bus.a >> sh;
            4'd12: sc_res = bus.a | bus.b;
            4'd13: sc_res = bus.a & bus.b;
            4'd14: begin
                sc_res = dif[WIDTH-1:0];
                sc_c = dif[WIDTH];
                sc_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd15: begin
                sc_res = sum[WIDTH-1:0];
                sc_c = sum[WIDTH];
                sc_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: ;
        endcase
    end
    // multiply: {hi,lo} starts as {0,multiplier} and shifts right one partial product per cycle
    assign madd = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    assign m_hi = madd[WIDTH:1];
    assign m_lo = {madd[0], lo[WIDTH-1:1]};
    // divide: hi is the partial remainder, lo shifts the dividend out and the quotient in
    assign rs = {hi, lo[WIDTH-1]};
    assign dsub = rs - {1'b0, opd};
    assign d_ok = ~dsub[WIDTH];
    assign d_hi = d_ok ? dsub[WIDTH-1:0] : rs[WIDTH-1:0];
    assign d_lo = {lo[WIDTH-2:0], d_ok};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            opd <= '0;
            hi <= '0;
            lo <= '0;
            bus.out_valid <= 1'b0;
            bus.result <= '0;
            bus.result_hi <= '0;
            bus.flag_zero <= 1'b0;
            bus.flag_carry <= 1'b0;
            bus.flag_ovf <= 1'b0;
            bus.flag_dz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    cnt <= (SHW+1)'(WIDTH);
                    hi <= '0;
                    if (op == 4'd1) begin
                        opd <= bus.a;
                        lo <= bus.b;
                        state <= MULT;
                    end else if (op == 4'd2) begin
                        opd <= bus.b;
                        lo <= bus.a;
                        state <= DIV;
                    end else begin
                        bus.result <= sc_res;
                        bus.result_hi <= '0;
                        bus.flag_zero <= sc_res == '0;
                        bus.flag_carry <= sc_c;
                        bus.flag_ovf <= sc_v;
                        bus.flag_dz <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                MULT: begin
                    hi <= m_hi;
                    lo <= m_lo;
                    cnt <= cnt - (SHW+1)'(1);
                    if (cnt == (SHW+1)'(1)) begin
                        bus.result <= m_lo;
                        bus.result_hi <= m_hi;
                        bus.flag_zero <= m_lo == '0;
                        bus.flag_carry <= 1'b0;
                        bus.flag_ovf <= 1'b0;
                        bus.flag_dz <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DIV: begin
                    hi <= d_hi;
                    lo <= d_lo;
                    cnt <= cnt - (SHW+1)'(1);
                    // a zero divisor still runs all iterations; hi ends up holding the dividend
                    if (cnt == (SHW+1)'(1)) begin
                        bus.result <= opd == '0 ? '1 : d_lo;
                        bus.result_hi <= d_hi;
                        bus.flag_zero <= opd != '0 && d_lo == '0;
                        bus.flag_carry <= 1'b0;
                        bus.flag_ovf <= 1'b0;
                        bus.flag_dz <= opd == '0;
                        bus.out_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
